// File: rtl/idli_utx_m.sv
// idli_utx_m -- UART transmitter.
//
// Accepts one 16b word from EX as four 4b slices over an aligned ctr group
// (ctr==0 carries bits [3:0], ctr==3 carries bits [15:12]). It then sends the
// word as two 8b frames, low byte first and LSB first within each byte. Each
// frame is preceded by a low start bit.
//
// Optional feature: define IDLI_UTX_STOP_BIT_EN to append a high stop bit
// after each byte. This gives a 20-cycle frame instead of 18 cycles.
//
// Ports:
//   i_utx_gck    core clock, all state updates on posedge
//   i_utx_rst_n  asynchronous active-low reset
//   i_utx_ctr    2b sync counter, slice position within a 16b group
//   i_utx_data   4b slice from EX
//   i_utx_vld    EX has a word to send (held for a full aligned group)
//   o_utx_acp    transmitter accepts slices this cycle
//   o_utx_data   serial line, idle high
module idli_utx_m (
  input  logic       i_utx_gck,
  input  logic       i_utx_rst_n,
  input  logic [1:0] i_utx_ctr,
  input  logic [3:0] i_utx_data,
  input  logic       i_utx_vld,
  output logic       o_utx_acp,
  output logic       o_utx_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  bits_q, bits_d;

  always_ff @(posedge i_utx_gck or negedge i_utx_rst_n) begin
    if (!i_utx_rst_n) begin
      state_q <= ST_IDLE;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
    end
  end

  // The shift buffer is fully reloaded before every transmission, so it
  // needs no reset.
  always_ff @(posedge i_utx_gck) begin
    data_q <= data_d;
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    bits_d     = bits_q;
    o_utx_acp  = 1'b0;
    o_utx_data = 1'b1;

    case (state_q)
      ST_IDLE: begin
        o_utx_acp = 1'b1;
        // Only start capturing on an aligned group boundary.
        if (i_utx_vld && (i_utx_ctr == 2'd0)) begin
          data_d  = {i_utx_data, data_q[15:4]};
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        o_utx_acp = 1'b1;
        data_d    = {i_utx_data, data_q[15:4]};
        if (i_utx_ctr == 2'd3) begin
          bits_d  = '0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        o_utx_data = 1'b0;
        state_d    = ST_DATA;
      end

      ST_DATA: begin
        o_utx_data = data_q[0];
        data_d     = {1'b0, data_q[15:1]};
        bits_d     = bits_q + 4'd1;
`ifdef IDLI_UTX_STOP_BIT_EN
        if ((bits_q == 4'd7) || (bits_q == 4'd15)) begin
          state_d = ST_STOP;
        end
`else
        if (bits_q == 4'd7) begin
          state_d = ST_START;
        end else if (bits_q == 4'd15) begin
          state_d = ST_IDLE;
        end
`endif
      end

`ifdef IDLI_UTX_STOP_BIT_EN
      // bits_q is 8 after the low byte and wraps to 0 after the high byte.
      ST_STOP: begin
        o_utx_data = 1'b1;
        if (bits_q == 4'd8) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_idli_utx_m.sv
module tb_idli_utx_m;

  logic       gck = 1'b0;
  logic       rst_n;
  logic [1:0] ctr = '0;
  logic [3:0] data;
  logic       vld;
  logic       acp;
  logic       line;

  logic [15:0] drv_word;
  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          exp_q[$];

  idli_utx_m dut (
    .i_utx_gck   (gck),
    .i_utx_rst_n (rst_n),
    .i_utx_ctr   (ctr),
    .i_utx_data  (data),
    .i_utx_vld   (vld),
    .o_utx_acp   (acp),
    .o_utx_data  (line)
  );

  always #5 gck = ~gck;

  // Free-running sync counter shared with the rest of the core.
  always @(posedge gck) ctr <= ctr + 2'd1;

  // Reference model: the line sequence for one word is a start bit, then the
  // low byte LSB first, an optional stop bit, a start bit, the high byte LSB
  // first, and an optional stop bit.
  function automatic void build_exp(input logic [15:0] w);
    exp_q.delete();
    for (int b = 0; b < 2; b++) begin
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(w[8*b + i]);
`ifdef IDLI_UTX_STOP_BIT_EN
      exp_q.push_back(1'b1);
`endif
    end
  endfunction

  // Advance to the next negedge and present the slice for the new ctr.
  task automatic tick();
    @(negedge gck);
    data = drv_word[4*ctr +: 4];
  endtask

  // Wait for an aligned group, then present all four slices of w. On return
  // the bench sits at the negedge where the start bit should be on the line.
  task automatic load_word(input logic [15:0] w, input logic keep_vld);
    while (ctr != 2'd0) tick();
    drv_word = w;
    data     = w[3:0];
    vld      = 1'b1;
    repeat (4) tick();
    vld = keep_vld;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vld   = 1'b0;
    drv_word = '0;
    data  = '0;
    repeat (3) tick();
    total++;
    if (line !== 1'b1 || acp !== 1'b1) begin
      bad++;
      $display("FAIL reset_hold line=%b acp=%b expected line=1 acp=1", line, acp);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      total++;
      if (line !== 1'b1 || acp !== 1'b1) begin
        bad++;
        $display("FAIL reset_idle[%0d] line=%b acp=%b expected line=1 acp=1", i, line, acp);
      end
    end
  endtask

  task automatic test_known_word();
    load_word(16'h1234, 1'b0);
    build_exp(16'h1234);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (line !== exp_q[i] || acp !== 1'b0) begin
        bad++;
        $display("FAIL word1234[%0d] line=%b acp=%b expected line=%b acp=0", i, line, acp, exp_q[i]);
      end
      tick();
    end
    total++;
    if (line !== 1'b1 || acp !== 1'b1) begin
      bad++;
      $display("FAIL word1234_end line=%b acp=%b expected line=1 acp=1", line, acp);
    end
  endtask

  task automatic test_misaligned();
    while (ctr != 2'd2) tick();
    drv_word = 16'hFFFF;
    data     = 4'hF;
    vld      = 1'b1;
    // Two cycles of ignored vld at ctr 2 and 3, then four capture cycles.
    for (int i = 0; i < 6; i++) begin
      total++;
      if (line !== 1'b1 || acp !== 1'b1) begin
        bad++;
        $display("FAIL misaligned_pre[%0d] line=%b acp=%b expected line=1 acp=1", i, line, acp);
      end
      tick();
    end
    vld = 1'b0;
    build_exp(16'hFFFF);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (line !== exp_q[i] || acp !== 1'b0) begin
        bad++;
        $display("FAIL misaligned[%0d] line=%b acp=%b expected line=%b acp=0", i, line, acp, exp_q[i]);
      end
      tick();
    end
    total++;
    if (line !== 1'b1 || acp !== 1'b1) begin
      bad++;
      $display("FAIL misaligned_end line=%b acp=%b expected line=1 acp=1", line, acp);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned gap;
    load_word(16'h0000, 1'b1);
    drv_word = 16'hA5C3;
    data     = drv_word[4*ctr +: 4];
    build_exp(16'h0000);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (line !== exp_q[i] || acp !== 1'b0) begin
        bad++;
        $display("FAIL b2b_first[%0d] line=%b acp=%b expected line=%b acp=0", i, line, acp, exp_q[i]);
      end
      tick();
    end
    // Idle until ctr wraps to 0, then four capture cycles.
    gap = (4 - int'(ctr)) % 4 + 4;
    for (int i = 0; i < gap; i++) begin
      total++;
      if (line !== 1'b1 || acp !== 1'b1) begin
        bad++;
        $display("FAIL b2b_gap[%0d] line=%b acp=%b expected line=1 acp=1", i, line, acp);
      end
      tick();
    end
    vld = 1'b0;
    build_exp(16'hA5C3);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (line !== exp_q[i] || acp !== 1'b0) begin
        bad++;
        $display("FAIL b2b_second[%0d] line=%b acp=%b expected line=%b acp=0", i, line, acp, exp_q[i]);
      end
      tick();
    end
    total++;
    if (line !== 1'b1 || acp !== 1'b1) begin
      bad++;
      $display("FAIL b2b_end line=%b acp=%b expected line=1 acp=1", line, acp);
    end
  endtask

  task automatic test_reset_mid();
    load_word(16'h0000, 1'b0);
    // Start bit plus bits 0..4, landing on bit 5 (bits_q==5).
    repeat (6) tick();
    total++;
    if (line !== 1'b0 || acp !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_pre line=%b acp=%b expected line=0 acp=0", line, acp);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (line !== 1'b1 || acp !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_async line=%b acp=%b expected line=1 acp=1", line, acp);
    end
    tick();
    rst_n = 1'b1;
    tick();
    load_word(16'h00FF, 1'b0);
    build_exp(16'h00FF);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (line !== exp_q[i] || acp !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_word[%0d] line=%b acp=%b expected line=%b acp=0", i, line, acp, exp_q[i]);
      end
      tick();
    end
    total++;
    if (line !== 1'b1 || acp !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_end line=%b acp=%b expected line=1 acp=1", line, acp);
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int n = 0; n < 8; n++) begin
      w = 16'($urandom);
      repeat ($urandom_range(0, 5)) tick();
      load_word(w, 1'b0);
      build_exp(w);
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (line !== exp_q[i] || acp !== 1'b0) begin
          bad++;
          $display("FAIL random_%04h[%0d] line=%b acp=%b expected line=%b acp=0", w, i, line, acp, exp_q[i]);
        end
        tick();
      end
      total++;
      if (line !== 1'b1 || acp !== 1'b1) begin
        bad++;
        $display("FAIL random_%04h_end line=%b acp=%b expected line=1 acp=1", w, line, acp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_word();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
